// File: rtl/ddr4_mem_model.sv
// ddr4_mem_model
// Behavioural stand-in for the DDR4 controller IP used in system smoke tests.
// After reset it runs a fixed-length calibration countdown. It then serves a
// 256-bit AXI4 slave (INCR bursts only) backed by on-chip storage. No DRAM pins
// are modelled.
//
// Ports:
//   c0_sys_clk_p / c0_sys_clk_n  clock (rising edge of _p); _n is unused
//   sys_rst                      synchronous, active-high reset
//   c0_init_calib_complete       sticky calibration-done flag
//   s_axi_aw* / s_axi_w* / s_axi_b*   write address, data and response channels
//   s_axi_ar* / s_axi_r*              read address and data channels
//   dbg_wr_state / dbg_rd_state       current write / read FSM state
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high. A source holds valid and its payload stable
// until that edge. Ready may be raised or lowered freely.
module ddr4_mem_model #(
  parameter int CALIB_CYCLES = 1000,
  parameter int ADDR_W       = 32,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic              c0_sys_clk_p,
  input  logic              c0_sys_clk_n,
  input  logic              sys_rst,
  output logic              c0_init_calib_complete,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [255:0]      s_axi_wdata,
  input  logic [31:0]       s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [255:0]      s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [1:0]        dbg_wr_state,
  output logic              dbg_rd_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

  logic [255:0] mem [DEPTH];

  logic [31:0]           calib_cnt;
  w_state_t              w_state;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic                  w_err;
  r_state_t              r_state;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic                  r_wait;
  logic                  w_fire;
  logic                  w_final;

  assign w_fire       = s_axi_wvalid & s_axi_wready;
  assign w_final      = (w_beat == w_len);
  assign s_axi_rresp  = 2'b00;
  assign dbg_wr_state = w_state;
  assign dbg_rd_state = r_state;

  // Address bits outside the word index, and the complement clock, are ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, c0_sys_clk_n,
                         s_axi_awaddr[ADDR_W-1:5+DEPTH_LOG2], s_axi_awaddr[4:0],
                         s_axi_araddr[ADDR_W-1:5+DEPTH_LOG2], s_axi_araddr[4:0]};

  // Calibration countdown: the CALIB_CYCLES-th edge with reset low sets the flag.
  always_ff @(posedge c0_sys_clk_p) begin
    if (sys_rst) begin
      calib_cnt              <= '0;
      c0_init_calib_complete <= 1'b0;
    end else if (!c0_init_calib_complete) begin
      calib_cnt <= calib_cnt + 32'd1;
      if (calib_cnt == 32'(CALIB_CYCLES - 1)) c0_init_calib_complete <= 1'b1;
    end
  end

  // Write FSM. The burst length alone decides when the burst ends. wlast only
  // feeds the response code.
  always_ff @(posedge c0_sys_clk_p) begin
    if (sys_rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awready && s_axi_awvalid) begin
            w_idx         <= s_axi_awaddr[5 +: DEPTH_LOG2];
            w_len         <= s_axi_awlen;
            w_beat        <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= c0_init_calib_complete;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx  <= w_idx + IDX_ONE;
            w_beat <= w_beat + 8'd1;
            if (w_final) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || !s_axi_wlast) ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end else if (s_axi_wlast) begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is never cleared. The reset guard drops a beat that lands in a
  // reset cycle, so a burst cut off by reset stops writing immediately.
  always_ff @(posedge c0_sys_clk_p) begin
    if (!sys_rst && w_state == W_DATA && w_fire) begin
      for (int b = 0; b < 32; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM. r_wait adds the idle cycle after the AR handshake, so the first
  // beat shows up two cycles after acceptance. Storage is sampled with
  // non-blocking reads, so a same-edge write to the same word is not seen.
  always_ff @(posedge c0_sys_clk_p) begin
    if (sys_rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_wait        <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arready && s_axi_arvalid) begin
            r_idx         <= s_axi_araddr[5 +: DEPTH_LOG2];
            r_len         <= s_axi_arlen;
            r_beat        <= '0;
            r_wait        <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= c0_init_calib_complete;
          end
        end
        R_DATA: begin
          if (r_wait) begin
            r_wait <= 1'b0;
          end else if (!s_axi_rvalid) begin
            s_axi_rdata  <= mem[r_idx];
            s_axi_rlast  <= (r_beat == r_len);
            s_axi_rvalid <= 1'b1;
          end else if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= mem[r_idx + IDX_ONE];
              s_axi_rlast <= ((r_beat + 8'd1) == r_len);
              r_idx       <= r_idx + IDX_ONE;
              r_beat      <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_mem_model.sv
// tb_ddr4_mem_model
// Randomised and directed bench for ddr4_mem_model. Storage is mirrored in a
// plain word array. Expected read beats come from that array through exp_q.
module tb_ddr4_mem_model;

  localparam int CALIB = 1000;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_n;
  always #5 clk = ~clk;
  assign clk_n = ~clk;

  logic         sys_rst = 1'b1;
  logic         calib;
  logic [31:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '0;
  logic         wlast = 1'b0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [31:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [1:0]   dbg_wr_state;
  logic         dbg_rd_state;

  ddr4_mem_model #(.CALIB_CYCLES(CALIB), .ADDR_W(32), .DEPTH_LOG2(10)) dut (
    .c0_sys_clk_p(clk), .c0_sys_clk_n(clk_n), .sys_rst(sys_rst),
    .c0_init_calib_complete(calib),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready), .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_pass = 0;
  logic [255:0] model_mem [DEPTH];
  logic [255:0] exp_q[$];
  logic [255:0] wd_q[$];
  logic [31:0]  ws_q[$];
  logic         wl_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int word_of(input logic [31:0] addr, input int beat);
    return (int'(addr / 32) + beat) % DEPTH;
  endfunction

  function automatic void model_write(input int idx, input logic [255:0] d, input logic [31:0] s);
    for (int b = 0; b < 32; b++) if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // Beat payloads for the next write. full_strb selects all-ones strobes.
  // bad_beat flips wlast on that beat (-1 leaves wlast correct).
  task automatic fill_wq(input int len, input bit full_strb, input int bad_beat);
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    for (int b = 0; b <= len; b++) begin
      wd_q.push_back(rand256());
      ws_q.push_back(full_strb ? 32'hFFFF_FFFF : 32'($urandom));
      wl_q.push_back((b == len) != (b == bad_beat));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] addr, input int len, input string tag);
    int budget;
    logic [1:0] resp;
    logic [1:0] exp_resp;
    exp_resp = 2'b00;
    for (int b = 0; b <= len; b++) if (wl_q[b] != (b == len)) exp_resp = 2'b10;
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    budget = 0;
    while (!awready && budget < 200) begin step(); budget++; end
    if (!awready) begin check({tag, "_aw_timeout"}, 0, 1); awvalid = 1'b0; return; end
    step();
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      repeat ($urandom_range(0, 1)) step();
      wvalid = 1'b1; wdata = wd_q[b]; wstrb = ws_q[b]; wlast = wl_q[b];
      budget = 0;
      while (!wready && budget < 50) begin step(); budget++; end
      if (!wready) begin check({tag, "_w_timeout"}, 0, 1); wvalid = 1'b0; return; end
      step();
      model_write(word_of(addr, b), wd_q[b], ws_q[b]);
      wvalid = 1'b0; wlast = 1'b0;
    end
    check({tag, "_wready_off"}, wready, 0);
    budget = 0;
    while (!bvalid && budget < 50) begin step(); budget++; end
    if (!bvalid) begin check({tag, "_b_timeout"}, 0, 1); return; end
    resp = bresp;
    repeat ($urandom_range(0, 2)) begin
      step();
      check({tag, "_b_hold"}, {bvalid, bresp}, {1'b1, resp});
    end
    check({tag, "_bresp"}, resp, exp_resp);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check({tag, "_bvalid_off"}, bvalid, 0);
  endtask

  // mode 0: rready always high, 1: toggles every cycle, 2: random
  task automatic do_read(input logic [31:0] addr, input int len, input int mode, input string tag);
    int budget;
    int beat;
    bit acc;
    bit stalled;
    logic [255:0] held;
    exp_q.delete();
    for (int b = 0; b <= len; b++) exp_q.push_back(model_mem[word_of(addr, b)]);
    rready = 1'b0;
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    budget = 0;
    while (!arready && budget < 200) begin step(); budget++; end
    if (!arready) begin check({tag, "_ar_timeout"}, 0, 1); arvalid = 1'b0; return; end
    step();
    arvalid = 1'b0;
    check({tag, "_lat0"}, rvalid, 0);
    step();
    check({tag, "_lat1"}, rvalid, 0);
    step();
    check({tag, "_lat2"}, rvalid, 1);
    beat = 0; budget = 0; stalled = 1'b0; held = '0;
    while (beat <= len && budget < 2000) begin
      case (mode)
        0: rready = 1'b1;
        1: rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) check({tag, "_hold"}, {rvalid, rdata}, {1'b1, held});
      acc = 1'b0;
      if (rvalid) begin
        check({tag, "_data"}, rdata, exp_q[0]);
        check({tag, "_last"}, rlast, (beat == len));
        check({tag, "_resp"}, rresp, 2'b00);
        acc = rready;
      end
      stalled = rvalid && !rready;
      held = rdata;
      step();
      budget++;
      if (acc) begin void'(exp_q.pop_front()); beat++; end
    end
    rready = 1'b0;
    if (beat <= len) begin check({tag, "_r_timeout"}, 0, 1); return; end
    check({tag, "_end"}, {rvalid, arready}, 2'b01);
  endtask

  task automatic reset_and_calib(input string tag);
    int early;
    int rdy_early;
    sys_rst = 1'b1;
    repeat (5) step();
    check({tag, "_rst_calib"}, calib, 0);
    check({tag, "_rst_ready"}, {awready, wready, arready}, 3'b000);
    check({tag, "_rst_valid"}, {bvalid, rvalid, rlast, bresp}, 5'b0);
    check({tag, "_rst_rdata"}, rdata, 0);
    sys_rst = 1'b0;
    early = 0; rdy_early = 0;
    for (int i = 1; i < CALIB; i++) begin
      step();
      if (calib) early++;
      if (awready || wready || arready) rdy_early++;
    end
    check({tag, "_calib_early"}, early, 0);
    check({tag, "_ready_early"}, rdy_early, 0);
    step();
    check({tag, "_calib_rise"}, calib, 1);
    step();
    check({tag, "_ready_up"}, {calib, awready, arready}, 3'b111);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int len;
    int bad;
    int budget;
    int nacc;
    step();
    reset_and_calib("init");

    // single-beat write/read
    wd_q = '{{32{8'hA5}}}; ws_q = '{32'hFFFF_FFFF}; wl_q = '{1'b1};
    do_write(32'h0, 0, "a5_w");
    do_read(32'h0, 0, 0, "a5_r");
    check("a5_direct", model_mem[0], {32{8'hA5}});

    // four-beat burst, read back with rready toggling
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    for (int b = 0; b < 4; b++) begin
      wd_q.push_back(256'(b + 1)); ws_q.push_back(32'hFFFF_FFFF); wl_q.push_back(b == 3);
    end
    do_write(32'h40, 3, "b4_w");
    do_read(32'h40, 3, 1, "b4_r");

    // partial strobe over a word of all ones
    wd_q = '{{256{1'b1}}}; ws_q = '{32'hFFFF_FFFF}; wl_q = '{1'b1};
    do_write(32'h100, 0, "ones_w");
    wd_q = '{256'h1234_5678}; ws_q = '{32'h0000_000F}; wl_q = '{1'b1};
    do_write(32'h100, 0, "strb_w");
    check("strb_model", model_mem[8], {{224{1'b1}}, 32'h1234_5678});
    do_read(32'h100, 0, 0, "strb_r");

    // early wlast on a two-beat burst -> SLVERR, data still written
    fill_wq(1, 1'b1, 0);
    do_write(32'h140, 1, "slverr_w");
    do_read(32'h140, 1, 0, "slverr_r");

    // aliasing: 32*DEPTH maps to word 0
    fill_wq(0, 1'b1, -1);
    do_write(32 * DEPTH, 0, "alias_w");
    do_read(32'h0, 0, 0, "alias_r");

    // burst wrapping past the top of storage
    fill_wq(3, 1'b1, -1);
    do_write(32 * (DEPTH - 2), 3, "wrap_w");
    do_read(32 * (DEPTH - 2), 3, 2, "wrap_r");

    // maximum burst length
    fill_wq(255, 1'b1, -1);
    do_write(32'h2000, 255, "len256_w");
    do_read(32'h2000, 255, 0, "len256_r");

    // random traffic over a prefilled region (words 32..95)
    fill_wq(63, 1'b1, -1);
    do_write(32'h400, 63, "prefill_w");
    for (int it = 0; it < 20; it++) begin
      idx = 32 + $urandom_range(0, 56);
      len = $urandom_range(0, 7);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      fill_wq(len, 1'b0, bad);
      do_write(32'(idx * 32 + $urandom_range(0, 31)), len, "rnd_w");
      idx = 32 + $urandom_range(0, 56);
      do_read(32'(idx * 32 + $urandom_range(0, 31)), $urandom_range(0, 7), 2, "rnd_r");
    end

    // concurrent write and read on disjoint words
    for (int it = 0; it < 3; it++) begin
      fill_wq(7, 1'b0, -1);
      fork
        do_write(32'h400, 7, "conc_w");
        do_read(32'h800, 7, 2, "conc_r");
      join
    end

    // reset in the middle of a read burst
    araddr = 32'h2000; arlen = 8'd7; arvalid = 1'b1;
    budget = 0;
    while (!arready && budget < 50) begin step(); budget++; end
    step();
    arvalid = 1'b0;
    rready = 1'b1;
    nacc = 0; budget = 0;
    while (nacc < 2 && budget < 50) begin
      if (rvalid) nacc++;
      step();
      budget++;
    end
    check("midrst_streaming", rvalid, 1);
    sys_rst = 1'b1;
    step();
    rready = 1'b0;
    check("midrst_rvalid", {rvalid, rlast, arready}, 3'b000);
    reset_and_calib("rerst");
    do_read(32'h40, 3, 0, "survive_r");
    do_read(32'h2000, 15, 2, "survive2_r");
    do_read(32'h400, 63, 2, "survive3_r");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
